// File: rtl/check_node_sort_ctrl_pkg.sv
// Shared types for the check-node sorted-message list controller.
// Cell field widths are fixed here; the controller's Width/Sym_Width defaults track them.
package check_node_sort_ctrl_pkg;

  localparam int CELL_DATA_W = 6;
  localparam int CELL_SYM_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_t;

  localparam logic [CELL_DATA_W-1:0] EMPTY_VAL = '1;

  typedef struct packed {
    logic                   vld;
    logic [CELL_DATA_W-1:0] data;
    logic [CELL_SYM_W-1:0]  sym;
  } cell_t;

  localparam cell_t EMPTY_CELL = '{vld: 1'b0, data: EMPTY_VAL, sym: '0};

endpackage

// File: rtl/check_node_sort_ctrl_cmp.sv
// Per-cell reliability comparator: flags an input strictly more reliable than the stored cell.
module Comparer_for_CheckNode #(
  parameter int Width = 5
) (
  input  logic [Width:0] Cell_Data,
  input  logic [Width:0] Input_Data,
  output logic           lt
);

  assign lt = (Input_Data < Cell_Data);

endmodule

// File: rtl/check_node_sort_ctrl.sv
// Sorted insertion list for check-node messages: keeps the Depth most reliable
// (reliability, symbol) pairs of a frame in ascending order, then streams them out.
module check_node_sort_ctrl
  import check_node_sort_ctrl_pkg::*;
#(
  parameter int Width     = CELL_DATA_W - 1,
  parameter int Sym_Width = CELL_SYM_W,
  parameter int Depth     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Width:0]       in_data,
  input  logic [Sym_Width-1:0] in_sym,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Width:0]       out_data,
  output logic [Sym_Width-1:0] out_sym,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CW = $clog2(Depth + 1);

  state_t          state_q;
  cell_t           cells_q   [Depth];
  cell_t           cells_ins [Depth];
  cell_t           new_cell;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_ins;
  logic [Depth-1:0] cmp_lt;
  logic [Depth-1:0] lt;
  logic            ins_hit;

  assign in_ready = (state_q == ST_FILL);
  assign busy     = (state_q != ST_IDLE);
  assign new_cell = '{vld: 1'b1, data: in_data, sym: in_sym};

  for (genvar g = 0; g < Depth; g++) begin : g_cmp
    Comparer_for_CheckNode #(.Width(Width)) u_cmp (
      .Cell_Data  (cells_q[g].data),
      .Input_Data (in_data),
      .lt         (cmp_lt[g])
    );
    assign lt[g] = !cells_q[g].vld || cmp_lt[g];
  end

  assign ins_hit   = |lt;
  assign count_ins = (ins_hit && count_q != CW'(Depth)) ? count_q + 1'b1 : count_q;

  // Cells above the first raised lt keep their place, the first one takes the
  // input, and everything below it moves down one slot (old tail falls off).
  always_comb begin
    logic below;
    cells_ins[0] = lt[0] ? new_cell : cells_q[0];
    below        = lt[0];
    for (int k = 1; k < Depth; k++) begin
      cells_ins[k] = below ? cells_q[k-1] : (lt[k] ? new_cell : cells_q[k]);
      below        = below | lt[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sym   <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < Depth; k++) cells_q[k] <= EMPTY_CELL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FILL;
            count_q <= '0;
            for (int k = 0; k < Depth; k++) cells_q[k] <= EMPTY_CELL;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            for (int k = 0; k < Depth; k++) cells_q[k] <= cells_ins[k];
            count_q <= count_ins;
            if (in_last) begin
              state_q   <= ST_DRAIN;
              out_valid <= 1'b1;
              out_data  <= cells_ins[0].data;
              out_sym   <= cells_ins[0].sym;
              out_last  <= (count_ins == CW'(1));
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state_q   <= ST_IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_sym   <= '0;
              out_last  <= 1'b0;
            end else begin
              for (int k = 0; k < Depth - 1; k++) cells_q[k] <= cells_q[k+1];
              cells_q[Depth-1] <= EMPTY_CELL;
              count_q  <= count_q - 1'b1;
              out_data <= cells_q[1].data;
              out_sym  <= cells_q[1].sym;
              out_last <= (count_q == CW'(2));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
